cordic_datapath: RTL and testbench
==================================

Name: cordic_datapath

Overview:
- Iterative CORDIC rotation datapath: the responder to the sine/cosine FSM controller.
- Each control strobe from the controller (start, startLoop, t1/t2, verify, X/Y/angle) performs one register-transfer step.
- Returns status to the controller: angleGreaterA, doneLoop, done.
- Produces cos/sin of a signed Q3.13 input angle in the range −π/2 to +π/2.

Parameters:
- WIDTH, 16: datapath width. Signed two's complement, Q3.13. Fixed at 16 because the atan ROM is Q3.13.
- ITER, 12: number of CORDIC micro-rotations, 1..12.
- K_INIT, 4975: initial X value, 0.60725 in Q3.13 (gain pre-compensation).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- angle_in  in  WIDTH  target angle A, signed Q3.13; sampled on start
- start  in  1  load operands, clear state
- startLoop  in  1  clear iteration counter i and doneLoop
- t1_signal  in  1  t1 <= y >>> i
- t2_signal  in  1  t2 <= x >>> i
- verify_angleGreaterA  in  1  angleGreaterA <= (z > a), signed compare
- X_signal  in  1  x update
- Y_signal  in  1  y update
- angle_signal  in  1  z update, i increment
- angleGreaterA  out  1  registered compare result
- doneLoop  out  1  all ITER rotations applied
- done  out  1  results valid; level until next start
- cos_out  out  WIDTH  registered cos(A), Q3.13
- sin_out  out  WIDTH  registered sin(A), Q3.13

Behaviour:
- Reset (async, rst_n=0): all of the following cleared to 0 immediately:
  - registers x, y, z, a, t1, t2, i (4-bit)
  - outputs angleGreaterA, doneLoop, done, cos_out, sin_out
- Reset mid-iteration discards all state. No strobe has effect until the next start.
- start has priority over every other strobe in the same cycle. On start:
  - a <= angle_in, x <= K_INIT, y <= 0, z <= 0, i <= 0
  - angleGreaterA <= 0, doneLoop <= 0, done <= 0
  - cos_out and sin_out hold their previous values.
- All non-start strobes may coincide. Each strobe uses pre-edge register values, so t1/t2 captured in a cycle are not the ones consumed by X/Y in that same cycle.
- Update rules, with g = angleGreaterA and sat(i) = atan(2^-i) from the ROM:
  - X_signal: x <= g ? x + t1 : x − t1
  - Y_signal: y <= g ? y − t2 : y + t2
  - angle_signal: z <= g ? z − sat(i) : z + sat(i); i <= i + 1
- Arithmetic: WIDTH-bit wrap. No overflow occurs within the input range. Shifts are arithmetic (sign-preserving).
- atan ROM (Q3.13), i = 0..11: 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4.
- doneLoop: set on the edge where angle_signal is applied with i == ITER−1.
- While doneLoop = 1:
  - angle_signal, X_signal and Y_signal are ignored; x, y, z and i are frozen.
  - t1/t2/verify strobes still update their registers.
- done: one cycle after doneLoop rises, cos_out <= x, sin_out <= y and done <= 1. done holds until start or reset.
- startLoop: i <= 0, doneLoop <= 0; x, y, z untouched. done is not cleared.
- Per-iteration latency: the controller issues verify, then t1+t2, then X+Y+angle. That is 3 cycles per rotation, with results 1 cycle after doneLoop.

Optional Feature:
- Macro: CORDIC_ROUND_EN.
- Defined: t1/t2 use rounded shifts, (v + (1 << (i−1))) >>> i for i > 0; i = 0 is unchanged.
- Undefined: truncating arithmetic shift only.
- Both builds meet the ±8 LSB tolerance below.

Test Plan:
- Reset: assert rst_n=0 mid-iteration (i=5) -> all outputs 0 asynchronously. Subsequent X_signal/angle_signal without start leave x=y=0.
- angle_in=0, start, then 12 × (verify, t1+t2, X+Y+angle) -> doneLoop=1 after the 12th angle strobe; done=1 one cycle later; cos_out=8192±8, sin_out=0±8.
- angle_in=6434 (π/4) -> cos_out=5793±8, sin_out=5793±8. angle_in=−6434 -> cos_out=5793±8, sin_out=−5793±8.
- start and angle_signal in the same cycle with i=3 -> start wins: i=0, z=0, x=4975, done=0.
- After doneLoop=1, issue 3 extra angle_signal/X_signal strobes -> x, y, z and i unchanged. Then startLoop -> doneLoop=0, i=0, done stays 1.
- Rebuild with CORDIC_ROUND_EN defined and repeat the π/4 case -> 5793±8 on both outputs.

Source files
------------

// File: rtl/cordic_if.sv
// Controller-to-datapath bus for the CORDIC sine/cosine engine: per-step strobes, operand and status/results.
interface cordic_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] angle_in;
  logic                    start;
  logic                    startLoop;
  logic                    t1_signal;
  logic                    t2_signal;
  logic                    verify_angleGreaterA;
  logic                    X_signal;
  logic                    Y_signal;
  logic                    angle_signal;
  logic                    angleGreaterA;
  logic                    doneLoop;
  logic                    done;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;

  modport master (
    output angle_in, start, startLoop, t1_signal, t2_signal, verify_angleGreaterA,
           X_signal, Y_signal, angle_signal,
    input  angleGreaterA, doneLoop, done, cos_out, sin_out
  );

  modport slave (
    input  angle_in, start, startLoop, t1_signal, t2_signal, verify_angleGreaterA,
           X_signal, Y_signal, angle_signal,
    output angleGreaterA, doneLoop, done, cos_out, sin_out
  );
endinterface

// File: rtl/cordic_datapath.sv
// Iterative CORDIC rotation datapath (Q3.13), one register transfer per controller strobe.
// Define CORDIC_ROUND_EN for round-to-nearest t1/t2 shifts instead of truncating shifts.
module cordic_datapath #(
    parameter int WIDTH  = 16,
    parameter int ITER   = 12,
    parameter int K_INIT = 4975
) (
    input logic     clk,
    input logic     rst_n,
    cordic_if.slave bus
);

    typedef logic signed [WIDTH-1:0] word_t;

    word_t      x, y, z, a, t1, t2;
    logic [3:0] i;
    logic       loaded;
    logic       loop_q;

    function automatic word_t atan_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    return word_t'(6434);
            4'd1:    return word_t'(3798);
            4'd2:    return word_t'(2007);
            4'd3:    return word_t'(1019);
            4'd4:    return word_t'(511);
            4'd5:    return word_t'(256);
            4'd6:    return word_t'(128);
            4'd7:    return word_t'(64);
            4'd8:    return word_t'(32);
            4'd9:    return word_t'(16);
            4'd10:   return word_t'(8);
            4'd11:   return word_t'(4);
            default: return '0;
        endcase
    endfunction

    function automatic word_t shr(input word_t v, input logic [3:0] s);
`ifdef CORDIC_ROUND_EN
        if (s == 4'd0) return v;
        return (v + (word_t'(1) <<< (s - 4'd1))) >>> s;
`else
        return v >>> s;
`endif
    endfunction

    // loaded gates every non-start strobe so a reset leaves the datapath inert until start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x                 <= '0;
            y                 <= '0;
            z                 <= '0;
            a                 <= '0;
            t1                <= '0;
            t2                <= '0;
            i                 <= '0;
            loaded            <= 1'b0;
            loop_q            <= 1'b0;
            bus.angleGreaterA <= 1'b0;
            bus.doneLoop      <= 1'b0;
            bus.done          <= 1'b0;
            bus.cos_out       <= '0;
            bus.sin_out       <= '0;
        end else if (bus.start) begin
            a                 <= bus.angle_in;
            x                 <= word_t'(K_INIT);
            y                 <= '0;
            z                 <= '0;
            i                 <= '0;
            loaded            <= 1'b1;
            loop_q            <= 1'b0;
            bus.angleGreaterA <= 1'b0;
            bus.doneLoop      <= 1'b0;
            bus.done          <= 1'b0;
        end else if (loaded) begin
            loop_q <= bus.doneLoop;
            if (bus.t1_signal) t1 <= shr(y, i);
            if (bus.t2_signal) t2 <= shr(x, i);
            if (bus.verify_angleGreaterA) bus.angleGreaterA <= (z > a);
            if (!bus.doneLoop) begin
                if (bus.X_signal) x <= bus.angleGreaterA ? x + t1 : x - t1;
                if (bus.Y_signal) y <= bus.angleGreaterA ? y - t2 : y + t2;
                if (bus.angle_signal) begin
                    z <= bus.angleGreaterA ? z - atan_rom(i) : z + atan_rom(i);
                    i <= i + 4'd1;
                    if (i == 4'(ITER - 1)) bus.doneLoop <= 1'b1;
                end
            end
            if (bus.startLoop) begin
                i            <= '0;
                bus.doneLoop <= 1'b0;
            end
            // results latch on the cycle after doneLoop rises; x/y are frozen by then
            if (bus.doneLoop && !loop_q) begin
                bus.cos_out <= x;
                bus.sin_out <= y;
                bus.done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_datapath.sv
// Directed testbench for cordic_datapath: reset, three rotation angles, freeze, start priority.
module tb_cordic_datapath;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    cordic_if #(.WIDTH(16)) bus ();

    cordic_datapath #(.WIDTH(16), .ITER(12), .K_INIT(4975)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input bit st, input bit sl, input bit v, input bit t, input bit m);
        @(negedge clk);
        bus.start = st;
        bus.startLoop = sl;
        bus.verify_angleGreaterA = v;
        bus.t1_signal = t;
        bus.t2_signal = t;
        bus.X_signal = m;
        bus.Y_signal = m;
        bus.angle_signal = m;
        @(posedge clk);
        #1;
        bus.start = 0;
        bus.startLoop = 0;
        bus.verify_angleGreaterA = 0;
        bus.t1_signal = 0;
        bus.t2_signal = 0;
        bus.X_signal = 0;
        bus.Y_signal = 0;
        bus.angle_signal = 0;
    endtask

    task automatic rotate(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 1);
        end
    endtask

    task automatic run_angle(input string name, input int ang, input int ecos, input int esin,
                             input int xcos, input int xsin);
        int d;
        bus.angle_in = 16'(ang);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        rotate(11);
        checks++;
        if (bus.doneLoop !== 1'b0) begin
            errors++;
            $display("FAIL %s doneLoop_early: got %0b expected 0", name, bus.doneLoop);
        end
        rotate(1);
        checks++;
        if (bus.doneLoop !== 1'b1) begin
            errors++;
            $display("FAIL %s doneLoop: got %0b expected 1", name, bus.doneLoop);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_early: got %0b expected 0", name, bus.done);
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %0b expected 1", name, bus.done);
        end
        d = int'(bus.cos_out) - ecos;
        checks++;
        if (d > 8 || d < -8) begin
            errors++;
            $display("FAIL %s cos: got %0d expected %0d+-8", name, bus.cos_out, ecos);
        end
        d = int'(bus.sin_out) - esin;
        checks++;
        if (d > 8 || d < -8) begin
            errors++;
            $display("FAIL %s sin: got %0d expected %0d+-8", name, bus.sin_out, esin);
        end
`ifndef CORDIC_ROUND_EN
        checks++;
        if (int'(bus.cos_out) != xcos) begin
            errors++;
            $display("FAIL %s cos_exact: got %0d expected %0d", name, bus.cos_out, xcos);
        end
        checks++;
        if (int'(bus.sin_out) != xsin) begin
            errors++;
            $display("FAIL %s sin_exact: got %0d expected %0d", name, bus.sin_out, xsin);
        end
`else
        if (xcos == 0 && xsin == 0) $display("note: %s exact values not tracked", name);
`endif
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.angleGreaterA, bus.doneLoop, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000",
                     {bus.angleGreaterA, bus.doneLoop, bus.done});
        end
        checks++;
        if (bus.cos_out !== 16'sd0 || bus.sin_out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_outputs: got cos=%0d sin=%0d expected 0 0", bus.cos_out, bus.sin_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_freeze;
        cyc(0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);
        checks++;
        if (dut.i !== 4'd12) begin
            errors++;
            $display("FAIL freeze_i: got %0d expected 12", dut.i);
        end
        checks++;
        if (bus.doneLoop !== 1'b1) begin
            errors++;
            $display("FAIL freeze_doneLoop: got %0b expected 1", bus.doneLoop);
        end
`ifndef CORDIC_ROUND_EN
        checks++;
        if (int'(dut.x) != 8193 || int'(dut.y) != -1 || int'(dut.z) != -3) begin
            errors++;
            $display("FAIL freeze_xyz: got %0d %0d %0d expected 8193 -1 -3", dut.x, dut.y, dut.z);
        end
`endif
        cyc(0, 1, 0, 0, 0);
        checks++;
        if (bus.doneLoop !== 1'b0 || dut.i !== 4'd0) begin
            errors++;
            $display("FAIL startLoop: got doneLoop=%0b i=%0d expected 0 0", bus.doneLoop, dut.i);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL startLoop_done: got %0b expected 1", bus.done);
        end
    endtask

    task automatic test_start_priority;
        int d;
        bus.angle_in = 16'sd1000;
        cyc(1, 0, 0, 0, 0);
        rotate(3);
        checks++;
        if (dut.i !== 4'd3) begin
            errors++;
            $display("FAIL prio_i3: got %0d expected 3", dut.i);
        end
        bus.angle_in = 16'sd2000;
        cyc(1, 0, 1, 1, 1);
        checks++;
        if (dut.i !== 4'd0 || dut.z !== 16'sd0 || dut.x !== 16'sd4975 || dut.y !== 16'sd0) begin
            errors++;
            $display("FAIL prio_state: got i=%0d z=%0d x=%0d y=%0d expected 0 0 4975 0",
                     dut.i, dut.z, dut.x, dut.y);
        end
        checks++;
        if (dut.a !== 16'sd2000) begin
            errors++;
            $display("FAIL prio_a: got %0d expected 2000", dut.a);
        end
        checks++;
        if ({bus.done, bus.doneLoop, bus.angleGreaterA} !== 3'b000) begin
            errors++;
            $display("FAIL prio_flags: got %b expected 000",
                     {bus.done, bus.doneLoop, bus.angleGreaterA});
        end
        d = int'(bus.cos_out) - 5793;
        checks++;
        if (d > 8 || d < -8) begin
            errors++;
            $display("FAIL prio_cos_hold: got %0d expected 5793+-8", bus.cos_out);
        end
    endtask

    task automatic test_reset_mid;
        bus.angle_in = 16'sd6434;
        cyc(1, 0, 0, 0, 0);
        rotate(5);
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (dut.i !== 4'd5) begin
            errors++;
            $display("FAIL mid_i5: got %0d expected 5", dut.i);
        end
`ifndef CORDIC_ROUND_EN
        checks++;
        if (bus.angleGreaterA !== 1'b1) begin
            errors++;
            $display("FAIL mid_g: got %0b expected 1", bus.angleGreaterA);
        end
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.angleGreaterA, bus.doneLoop, bus.done} !== 3'b000 ||
            bus.cos_out !== 16'sd0 || bus.sin_out !== 16'sd0) begin
            errors++;
            $display("FAIL async_reset: got g=%0b dl=%0b d=%0b cos=%0d sin=%0d expected all 0",
                     bus.angleGreaterA, bus.doneLoop, bus.done, bus.cos_out, bus.sin_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 1, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 1);
        checks++;
        if (dut.x !== 16'sd0 || dut.y !== 16'sd0 || dut.z !== 16'sd0 || dut.i !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_inert: got x=%0d y=%0d z=%0d i=%0d expected 0 0 0 0",
                     dut.x, dut.y, dut.z, dut.i);
        end
    endtask

    initial begin
        bus.angle_in = '0;
        bus.start = 0;
        bus.startLoop = 0;
        bus.verify_angleGreaterA = 0;
        bus.t1_signal = 0;
        bus.t2_signal = 0;
        bus.X_signal = 0;
        bus.Y_signal = 0;
        bus.angle_signal = 0;
        test_reset;
        run_angle("zero", 0, 8192, 0, 8193, -1);
        test_freeze;
        run_angle("pos45", 6434, 5793, 5793, 5793, 5791);
        test_start_priority;
        run_angle("neg45", -6434, 5793, -5793, 5793, -5793);
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
